// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//   Multi-product vending controller. Accumulates credit from 1/2/5-unit
//   coins, vends one of NUM_PRODUCTS items at per-product prices, supports
//   cancel/refund and per-product sold-out flags, and pays change out as a
//   stream of 2-unit and 1-unit coins, one per cycle. All outputs are
//   registered.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   coin_in      in   00 none, 01 = 1, 10 = 2, 11 = 5 units
//   sel_valid    in   product selection strobe
//   sel_id       in   product index, valid with sel_valid
//   cancel       in   refund request
//   sold_out     in   per-product empty flags (level)
//   product_out  out  one-cycle vend pulse
//   product_id   out  index of the vended product, valid with product_out
//   coin_out     out  change coin this cycle: 00 none, 01 = 1, 10 = 2 units
//   credit       out  current credit
//   coin_reject  out  one-cycle pulse: coin of the previous cycle refused
//   sel_error    out  one-cycle pulse: selection of the previous cycle refused
//   busy         out  high while vending or paying out change
// ---------------------------------------------------------------------------
module vending_machine_multi #(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W        = 2,
  parameter int CREDIT_W     = 6,
  parameter int MAX_CREDIT   = 63,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {6'd12, 6'd10, 6'd7, 6'd5}
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              coin_in,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel_id,
  input  logic                    cancel,
  input  logic [NUM_PRODUCTS-1:0] sold_out,
  output logic                    product_out,
  output logic [SEL_W-1:0]        product_id,
  output logic [1:0]              coin_out,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    coin_reject,
  output logic                    sel_error,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t state, state_nxt;

  logic [CREDIT_W-1:0] credit_nxt;
  logic [1:0]          coin_out_nxt;
  logic                product_out_nxt;
  logic [SEL_W-1:0]    product_id_nxt;
  logic                coin_reject_nxt;
  logic                sel_error_nxt;
  logic                busy_nxt;

  // Selection lookup. Walking the product list avoids indexing the price
  // vector and sold_out with an index that might be out of range.
  logic                sel_known;
  logic                sel_sold;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_known = 1'b0;
    sel_sold  = 1'b0;
    sel_price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == SEL_W'(i)) begin
        sel_known = 1'b1;
        sel_sold  = sold_out[i];
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  // Selection is judged against the registered credit, not including any
  // coin arriving in the same cycle.
  assign sel_ok = sel_valid && sel_known && !sel_sold && (credit >= sel_price);

  // Coin value and overflow check on a one-bit-wider sum so it never wraps.
  logic [CREDIT_W:0] coin_val;
  logic [CREDIT_W:0] coin_sum;
  logic              coin_fits;

  always_comb begin
    unique case (coin_in)
      2'b01:   coin_val = (CREDIT_W+1)'(1);
      2'b10:   coin_val = (CREDIT_W+1)'(2);
      2'b11:   coin_val = (CREDIT_W+1)'(5);
      default: coin_val = '0;
    endcase
  end

  assign coin_sum  = {1'b0, credit} + coin_val;
  assign coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Next change coin and the credit left after paying it.
  logic                change_two;
  logic [1:0]          change_coin;
  logic [CREDIT_W-1:0] change_left;

  assign change_two  = (credit >= CREDIT_W'(2));
  assign change_coin = change_two ? 2'b10 : 2'b01;
  assign change_left = credit - (change_two ? CREDIT_W'(2) : CREDIT_W'(1));

  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit;
    coin_out_nxt    = 2'b00;
    product_out_nxt = 1'b0;
    product_id_nxt  = product_id;
    coin_reject_nxt = 1'b0;
    sel_error_nxt   = 1'b0;

    unique case (state)
      S_IDLE, S_CREDIT: begin
        if (cancel && (state == S_CREDIT)) begin
          // Refund starts on the same edge: the first coin is already out.
          state_nxt       = S_CHANGE;
          coin_out_nxt    = change_coin;
          credit_nxt      = change_left;
          coin_reject_nxt = (coin_in != 2'b00);
          sel_error_nxt   = sel_valid;
        end else if (sel_ok) begin
          state_nxt       = S_VEND;
          credit_nxt      = credit - sel_price;
          product_out_nxt = 1'b1;
          product_id_nxt  = sel_id;
          coin_reject_nxt = (coin_in != 2'b00);
        end else begin
          // A refused selection does not block a coin in the same cycle.
          sel_error_nxt = sel_valid;
          if (coin_in != 2'b00) begin
            if (coin_fits) begin
              credit_nxt = coin_sum[CREDIT_W-1:0];
              state_nxt  = S_CREDIT;
            end else begin
              coin_reject_nxt = 1'b1;
            end
          end
        end
      end

      S_VEND, S_CHANGE: begin
        coin_reject_nxt = (coin_in != 2'b00);
        sel_error_nxt   = sel_valid;
        if (credit != '0) begin
          state_nxt    = S_CHANGE;
          coin_out_nxt = change_coin;
          credit_nxt   = change_left;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == S_VEND) || (state_nxt == S_CHANGE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      coin_out    <= 2'b00;
      product_out <= 1'b0;
      product_id  <= '0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      coin_out    <= coin_out_nxt;
      product_out <= product_out_nxt;
      product_id  <= product_id_nxt;
      coin_reject <= coin_reject_nxt;
      sel_error   <= sel_error_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
//   Directed bench for vending_machine_multi with default parameters
//   (prices p0=5, p1=7, p2=10, p3=12, MAX_CREDIT=63). Inputs change one time
//   unit after the rising edge; outputs are compared at that same point,
//   so each comparison sees the registers loaded by the preceding edge.
//   Observed outputs are packed as {busy, product_out, coin_out[1:0],
//   coin_reject, sel_error, credit[5:0]}.
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] coin_in;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic [3:0] sold_out;
  logic       product_out;
  logic [1:0] product_id;
  logic [1:0] coin_out;
  logic [5:0] credit;
  logic       coin_reject;
  logic       sel_error;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  vending_machine_multi dut (
    .clock       (clock),
    .reset       (reset),
    .coin_in     (coin_in),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .cancel      (cancel),
    .sold_out    (sold_out),
    .product_out (product_out),
    .product_id  (product_id),
    .coin_out    (coin_out),
    .credit      (credit),
    .coin_reject (coin_reject),
    .sel_error   (sel_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  localparam logic [1:0] C0 = 2'b00, C1 = 2'b01, C2 = 2'b10, C5 = 2'b11;

  logic [11:0] snap;
  assign snap = {busy, product_out, coin_out, coin_reject, sel_error, credit};

  // Builds an expected snapshot from individual field values.
  function automatic logic [11:0] exp_of(input logic b, input logic p,
                                         input logic [1:0] c, input logic r,
                                         input logic s, input int cr);
    return {b, p, c, r, s, 6'(cr)};
  endfunction

  // One clock: apply inputs, pass the edge, then return inputs to idle.
  task automatic cycle(input logic [1:0] c, input logic sv,
                       input logic [1:0] sid, input logic cn);
    coin_in = c; sel_valid = sv; sel_id = sid; cancel = cn;
    @(posedge clock);
    #1;
    coin_in = C0; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sold_out = 4'b0000;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    // Power-on state while reset is held.
    vectors++;
    if (snap !== 12'h000) begin
      miscompares++;
      $display("FAIL por_state: got %h expected %h", snap, 12'h000);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    // Credit 7, cancel: first refund coin leaves 5 in CHANGE.
    cycle(C5, 0, 0, 0);
    cycle(C2, 0, 0, 0);
    cycle(C0, 0, 0, 1);
    e = exp_of(1, 0, C2, 0, 0, 5);
    vectors++;
    if (snap !== e) begin
      miscompares++;
      $display("FAIL reset_setup_change: got %h expected %h", snap, e);
    end
    // Asynchronous reset mid-cycle, away from any edge.
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (snap !== 12'h000 || product_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h id %0d expected %h id 0", snap, product_id, 12'h000);
    end
    @(negedge clock);
    reset = 1'b0;
    cycle(C0, 0, 0, 0);
    vectors++;
    if (snap !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_idle_after: got %h expected %h", snap, 12'h000);
    end
  endtask

  task automatic test_vend_change();
    logic [11:0] e [4];
    cycle(C5, 0, 0, 0);
    cycle(C2, 0, 0, 0);
    cycle(C1, 0, 0, 0);
    e[0] = exp_of(0, 0, C0, 0, 0, 8);
    vectors++;
    if (snap !== e[0]) begin
      miscompares++;
      $display("FAIL vend_credit8: got %h expected %h", snap, e[0]);
    end
    cycle(C0, 1, 2'd1, 0);
    vectors++;
    if (snap !== exp_of(1, 1, C0, 0, 0, 1) || product_id !== 2'd1) begin
      miscompares++;
      $display("FAIL vend_pulse: got %h id %0d expected %h id 1", snap, product_id, exp_of(1, 1, C0, 0, 0, 1));
    end
    e[1] = exp_of(1, 0, C1, 0, 0, 0);
    e[2] = exp_of(0, 0, C0, 0, 0, 0);
    e[3] = exp_of(0, 0, C0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      cycle(C0, 0, 0, 0);
      vectors++;
      if (snap !== e[i]) begin
        miscompares++;
        $display("FAIL vend_change_step%0d: got %h expected %h", i, snap, e[i]);
      end
    end
    // Exact-price purchase: no change, straight back to IDLE.
    cycle(C5, 0, 0, 0);
    cycle(C0, 1, 2'd0, 0);
    vectors++;
    if (snap !== exp_of(1, 1, C0, 0, 0, 0) || product_id !== 2'd0) begin
      miscompares++;
      $display("FAIL vend_exact: got %h id %0d expected %h id 0", snap, product_id, exp_of(1, 1, C0, 0, 0, 0));
    end
    cycle(C0, 0, 0, 0);
    vectors++;
    if (snap !== 12'h000) begin
      miscompares++;
      $display("FAIL vend_exact_idle: got %h expected %h", snap, 12'h000);
    end
  endtask

  task automatic test_sel_errors();
    cycle(C2, 0, 0, 0);
    cycle(C2, 0, 0, 0);
    cycle(C0, 1, 2'd2, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 1, 4)) begin
      miscompares++;
      $display("FAIL sel_short_credit: got %h expected %h", snap, exp_of(0, 0, C0, 0, 1, 4));
    end
    cycle(C0, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 0, 4)) begin
      miscompares++;
      $display("FAIL sel_error_pulse_end: got %h expected %h", snap, exp_of(0, 0, C0, 0, 0, 4));
    end
    cycle(C2, 0, 0, 0);
    sold_out = 4'b0001;
    cycle(C0, 1, 2'd0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 1, 6)) begin
      miscompares++;
      $display("FAIL sel_sold_out: got %h expected %h", snap, exp_of(0, 0, C0, 0, 1, 6));
    end
    // Refused selection does not block a coin in the same cycle.
    cycle(C1, 1, 2'd3, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 1, 7)) begin
      miscompares++;
      $display("FAIL sel_refused_with_coin: got %h expected %h", snap, exp_of(0, 0, C0, 0, 1, 7));
    end
    do_reset();
  endtask

  task automatic test_cancel();
    logic [11:0] e [5];
    // Cancel in IDLE does nothing.
    cycle(C0, 0, 0, 1);
    vectors++;
    if (snap !== 12'h000) begin
      miscompares++;
      $display("FAIL cancel_idle: got %h expected %h", snap, 12'h000);
    end
    cycle(C5, 0, 0, 0);
    cycle(C2, 0, 0, 0);
    e[0] = exp_of(1, 0, C2, 0, 0, 5);
    e[1] = exp_of(1, 0, C2, 0, 0, 3);
    e[2] = exp_of(1, 0, C2, 0, 0, 1);
    e[3] = exp_of(1, 0, C1, 0, 0, 0);
    e[4] = exp_of(0, 0, C0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(C0, 0, 0, (i == 0));
      vectors++;
      if (snap !== e[i]) begin
        miscompares++;
        $display("FAIL cancel_refund_step%0d: got %h expected %h", i, snap, e[i]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) cycle(C5, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 0, 60)) begin
      miscompares++;
      $display("FAIL ovf_credit60: got %h expected %h", snap, exp_of(0, 0, C0, 0, 0, 60));
    end
    cycle(C5, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 1, 0, 60)) begin
      miscompares++;
      $display("FAIL ovf_reject5: got %h expected %h", snap, exp_of(0, 0, C0, 1, 0, 60));
    end
    cycle(C2, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 0, 62)) begin
      miscompares++;
      $display("FAIL ovf_accept2: got %h expected %h", snap, exp_of(0, 0, C0, 0, 0, 62));
    end
    cycle(C1, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 0, 63)) begin
      miscompares++;
      $display("FAIL ovf_accept1_to_max: got %h expected %h", snap, exp_of(0, 0, C0, 0, 0, 63));
    end
    cycle(C1, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 1, 0, 63)) begin
      miscompares++;
      $display("FAIL ovf_reject1_at_max: got %h expected %h", snap, exp_of(0, 0, C0, 1, 0, 63));
    end
    cycle(C0, 0, 0, 0);
    vectors++;
    if (snap !== exp_of(0, 0, C0, 0, 0, 63)) begin
      miscompares++;
      $display("FAIL ovf_reject_pulse_end: got %h expected %h", snap, exp_of(0, 0, C0, 0, 0, 63));
    end
    do_reset();
  endtask

  task automatic test_priority();
    logic [11:0] e [6];
    cycle(C5, 0, 0, 0);
    cycle(C5, 0, 0, 0);
    // Cancel + select + coin together at credit 10, then a coin and a
    // select during the refund; the credit sequence is unaffected.
    e[0] = exp_of(1, 0, C2, 1, 1, 8);
    e[1] = exp_of(1, 0, C2, 0, 0, 6);
    e[2] = exp_of(1, 0, C2, 1, 0, 4);
    e[3] = exp_of(1, 0, C2, 0, 0, 2);
    e[4] = exp_of(1, 0, C2, 0, 1, 0);
    e[5] = exp_of(0, 0, C0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      unique case (i)
        0:       cycle(C1, 1, 2'd0, 1);
        2:       cycle(C5, 0, 2'd0, 1);
        4:       cycle(C0, 1, 2'd0, 0);
        default: cycle(C0, 0, 2'd0, 0);
      endcase
      vectors++;
      if (snap !== e[i]) begin
        miscompares++;
        $display("FAIL prio_step%0d: got %h expected %h", i, snap, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Accepted select beats a coin in the same cycle.
    cycle(C5, 0, 0, 0);
    cycle(C5, 0, 0, 0);
    cycle(C1, 1, 2'd2, 0);
    vectors++;
    if (snap !== exp_of(1, 1, C0, 1, 0, 0) || product_id !== 2'd2) begin
      miscompares++;
      $display("FAIL b2b_select_beats_coin: got %h id %0d expected %h id 2", snap, product_id, exp_of(1, 1, C0, 1, 0, 0));
    end
    cycle(C0, 0, 0, 0);
    vectors++;
    if (snap !== 12'h000) begin
      miscompares++;
      $display("FAIL b2b_idle: got %h expected %h", snap, 12'h000);
    end
    // New purchase right away: 12 units, select p3 (price 12).
    cycle(C5, 0, 0, 0);
    cycle(C5, 0, 0, 0);
    cycle(C2, 0, 0, 0);
    cycle(C0, 1, 2'd3, 0);
    vectors++;
    if (snap !== exp_of(1, 1, C0, 0, 0, 0) || product_id !== 2'd3) begin
      miscompares++;
      $display("FAIL b2b_vend_p3: got %h id %0d expected %h id 3", snap, product_id, exp_of(1, 1, C0, 0, 0, 0));
    end
  endtask

  initial begin
    reset     = 1'b1;
    coin_in   = C0;
    sel_valid = 1'b0;
    sel_id    = 2'd0;
    cancel    = 1'b0;
    sold_out  = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_vend_change();
    test_sel_errors();
    test_cancel();
    test_overflow();
    test_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised multi-product vending controller that succeeds the single-product, fixed-price FSM. It accumulates credit from three coin denominations and vends one of `NUM_PRODUCTS` items at per-product prices. It supports cancel/refund and per-product sold-out inputs, and returns change as a multi-cycle stream of coins. It sits between the coin acceptor/keypad front end and the dispenser/coin-hopper drivers.

## Interface
- `NUM_PRODUCTS`, 4, number of selectable products (≥2).
- `SEL_W`, 2, width of product index; must be ≥ clog2(`NUM_PRODUCTS`).
- `CREDIT_W`, 6, width of credit register.
- `MAX_CREDIT`, 63, highest accepted credit; must be ≤ 2^`CREDIT_W`−1.
- `PRICES`, {6'd12,6'd10,6'd7,6'd5}, flat `NUM_PRODUCTS`×`CREDIT_W` price list; product i is at bits [i*`CREDIT_W` +: `CREDIT_W`]. Defaults: p0=5, p1=7, p2=10, p3=12. Every price must be ≥1.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `coin_in` in 2: 00 = none, 01 = 1 unit, 10 = 2 units, 11 = 5 units; sampled every cycle.
- `sel_valid` in 1: product selection strobe.
- `sel_id` in `SEL_W`: product index, valid with `sel_valid`.
- `cancel` in 1: refund request.
- `sold_out` in `NUM_PRODUCTS`: per-product empty flag, level.
- `product_out` out 1: one-cycle vend pulse.
- `product_id` out `SEL_W`: index of the vended product; valid while `product_out`=1.
- `coin_out` out 2: change coin this cycle: 00 none, 01 = 1 unit, 10 = 2 units.
- `credit` out `CREDIT_W`: current credit.
- `coin_reject` out 1: one-cycle pulse; the coin in the previous cycle was refused and must be returned by the acceptor.
- `sel_error` out 1: one-cycle pulse; the previous selection was refused.
- `busy` out 1: high in VEND and CHANGE.

## Operation
- States: IDLE (credit = 0), CREDIT (credit > 0), VEND, CHANGE. All outputs are registered.
- IDLE/CREDIT, coin ≠ 00:
  - If credit + value ≤ `MAX_CREDIT`: credit += value, and the state moves to CREDIT.
  - Otherwise: credit is unchanged and `coin_reject` pulses.
- IDLE/CREDIT, `sel_valid`: evaluated against the registered credit.
  - Accept if `sel_id` < `NUM_PRODUCTS`, `sold_out[sel_id]`=0, and credit ≥ price: go to VEND and credit −= price.
  - Otherwise `sel_error` pulses and the state is unchanged.
- `cancel` in CREDIT goes to CHANGE with the full credit refunded. `cancel` in IDLE does nothing.
- Priority within one cycle is cancel > accepted select > coin. A coin that loses priority is rejected (`coin_reject`), and a select that loses to cancel gives `sel_error`.
- VEND lasts one cycle: `product_out`=1 and `product_id` holds the latched index. The next state is CHANGE if credit > 0, else IDLE.
- CHANGE, one coin per cycle:
  - If credit ≥ 2: `coin_out`=10 and credit −= 2.
  - Otherwise: `coin_out`=01 and credit −= 1.
  - The state goes to IDLE on the cycle credit reaches 0.
- In VEND/CHANGE, any coin gives `coin_reject`, any `sel_valid` gives `sel_error`, and `cancel` is ignored.
- Credit never wraps. The overflow check uses a `CREDIT_W`+1-bit sum.

## Timing
- Reset (async, any state): state = IDLE. `credit`, `coin_out`, `product_out`, `product_id`, `coin_reject`, `sel_error`, `busy` are all 0. An in-progress vend or refund is abandoned; credit is lost by design.
- Coin sampled at edge k: `credit` is updated after edge k; `coin_reject` is high during cycle k+1.
- Accepted select at edge k: `product_out` and `busy` are high in cycle k+1, and `credit` already shows the reduced value.
- First change coin appears in cycle k+2. A change of C units takes ceil(C/2) cycles of `coin_out`. `busy` drops in the cycle after the last coin.
- Cancel at edge k: first refund coin in cycle k+1.
- `product_out`, `coin_reject`, and `sel_error` are single-cycle pulses and never stretch.

## Test plan
- Reset mid-CHANGE (credit 5) → all outputs 0 asynchronously; `credit`=0; state is IDLE.
- Coins 5, 2, 1, then select p1 (price 7) → `credit` 8; `product_out`=1 with `product_id`=1 for one cycle; then `coin_out`=01 for one cycle; then IDLE, `busy`=0.
- Credit 4, select p2 (price 10) → `sel_error` pulse, credit stays 4. Set `sold_out[0]`=1 and select p0 with credit 6 → `sel_error`, no vend.
- Credit 7, `cancel` → `coin_out` sequence 10, 10, 10, 01; `credit` 5, 3, 1, 0; then IDLE.
- Credit 60, insert 5 → `coin_reject`, credit stays 60. Insert 2 → credit 62. Insert 1 → 63. Insert 1 → `coin_reject`, credit stays 63.
- Same cycle: cancel + select + coin at credit 10 → refund of 10 (five 10 coins), plus `sel_error` and `coin_reject`. Coin during CHANGE → `coin_reject`, credit sequence unaffected.
